wb_rf_write_arbiter: RTL and testbench

//  Sits between writeback and a single-write-port register file. Accepts up to three

---
 rtl/wb_rf_write_arbiter.sv | 146 ++++++++++++++
 tb/tb_wb_rf_write_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rf_write_arbiter.sv
// Write arbiter between a three-pipe VLIW writeback stage and a single-port
// register file. Resolves same-destination collisions inside one bundle,
// queues the surviving writes in program order and drains one per cycle.
module wb_rf_write_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_wr1,
  input  logic                         in_wr2,
  input  logic                         in_wr3,
  input  logic [ADDR_W-1:0]            in_dest1,
  input  logic [ADDR_W-1:0]            in_dest2,
  input  logic [ADDR_W-1:0]            in_dest3,
  input  logic [DATA_W-1:0]            in_data1,
  input  logic [DATA_W-1:0]            in_data2,
  input  logic [DATA_W-1:0]            in_data3,
  output logic                         stall,
  output logic                         rf_wr,
  output logic [ADDR_W-1:0]            rf_dest,
  output logic [DATA_W-1:0]            rf_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [2**ADDR_W-1:0]         pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] mem_dest [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  logic              keep1;
  logic              keep2;
  logic              keep3;
  logic              accept;
  logic              pop;
  logic [1:0]        push_cnt;
  logic [1:0]        push_n;
  logic [ADDR_W-1:0] push_dest [3];
  logic [DATA_W-1:0] push_data [3];
  logic [CNT_W-1:0]  count_next;
  logic [CNT_W-1:0]  free_next;
  logic              stall_next;
  logic [PTR_W-1:0]  offset;

  // Within a bundle the highest-numbered pipe wins a shared destination,
  // since it is the latest write in program order.
  assign keep3 = in_wr3;
  assign keep2 = in_wr2 && !(in_wr3 && (in_dest3 == in_dest2));
  assign keep1 = in_wr1 && !(in_wr2 && (in_dest2 == in_dest1))
                        && !(in_wr3 && (in_dest3 == in_dest1));

  assign accept     = !stall && !flush;
  assign pop        = (count != '0);
  assign push_n     = accept ? push_cnt : 2'd0;
  assign count_next = count + CNT_W'(push_n) - CNT_W'(pop);
  assign free_next  = CNT_W'(DEPTH) - count_next;
  assign stall_next = (free_next < CNT_W'(3));

  // Compact surviving writes into consecutive slots, preserving pipe order.
  always_comb begin
    push_cnt = 2'd0;
    for (int k = 0; k < 3; k++) begin
      push_dest[k] = '0;
      push_data[k] = '0;
    end
    if (keep1) begin
      push_dest[push_cnt] = in_dest1;
      push_data[push_cnt] = in_data1;
      push_cnt = push_cnt + 2'd1;
    end
    if (keep2) begin
      push_dest[push_cnt] = in_dest2;
      push_data[push_cnt] = in_data2;
      push_cnt = push_cnt + 2'd1;
    end
    if (keep3) begin
      push_dest[push_cnt] = in_dest3;
      push_data[push_cnt] = in_data3;
      push_cnt = push_cnt + 2'd1;
    end
  end

  // Queue storage needs no reset; validity is tracked by head and count.
  always_ff @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (k < int'(push_n)) begin
        mem_dest[tail + PTR_W'(k)] <= push_dest[k];
        mem_data[tail + PTR_W'(k)] <= push_data[k];
      end
    end
  end

  // Pointers, occupancy, registered stall and the register-file write port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      stall   <= 1'b0;
      rf_wr   <= 1'b0;
      rf_dest <= '0;
      rf_data <= '0;
    end else begin
      if (pop) begin
        rf_wr   <= 1'b1;
        rf_dest <= mem_dest[head];
        rf_data <= mem_data[head];
        head    <= head + PTR_W'(1);
      end else begin
        rf_wr   <= 1'b0;
      end
      tail  <= tail + PTR_W'(push_n);
      count <= count_next;
      stall <= stall_next;
    end
  end

  // Pending mask: every live queue slot plus the write currently on rf_*.
  always_comb begin
    pending = '0;
    offset  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - head;
      if (CNT_W'(offset) < count) begin
        pending[mem_dest[i]] = 1'b1;
      end
    end
    if (rf_wr) begin
      pending[rf_dest] = 1'b1;
    end
  end

  // An accepted bundle must always find room for three writes.
  always_ff @(posedge clock) begin
    if (reset_n && accept) begin
      assert (count <= CNT_W'(DEPTH - 3));
    end
  end

endmodule

// File: tb/tb_wb_rf_write_arbiter.sv
// Self-checking bench for wb_rf_write_arbiter: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_wb_rf_write_arbiter;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH+1);

  typedef struct {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic                clock;
  logic                reset_n;
  logic                flush;
  logic [2:0]          wr;
  logic [ADDR_W-1:0]   dest [3];
  logic [DATA_W-1:0]   data [3];
  logic                stall;
  logic                rf_wr;
  logic [ADDR_W-1:0]   rf_dest;
  logic [DATA_W-1:0]   rf_data;
  logic [CNT_W-1:0]    count;
  logic [2**ADDR_W-1:0] pending;

  // Reference model state
  wr_t               q[$];
  logic              m_stall;
  logic              m_rf_wr;
  logic [ADDR_W-1:0] m_rf_dest;
  logic [DATA_W-1:0] m_rf_data;

  int    errors = 0;
  int    checks = 0;
  string phase  = "init";
  bit    saw_stall = 0;

  wb_rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_wr1   (wr[0]),
    .in_wr2   (wr[1]),
    .in_wr3   (wr[2]),
    .in_dest1 (dest[0]),
    .in_dest2 (dest[1]),
    .in_dest3 (dest[2]),
    .in_data1 (data[0]),
    .in_data2 (data[1]),
    .in_data3 (data[2]),
    .stall    (stall),
    .rf_wr    (rf_wr),
    .rf_dest  (rf_dest),
    .rf_data  (rf_data),
    .count    (count),
    .pending  (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_stall   = 1'b0;
    m_rf_wr   = 1'b0;
    m_rf_dest = '0;
    m_rf_data = '0;
  endtask

  // One clock edge of the behavioural model: pop the oldest write (if any was
  // queued before the edge), then append this bundle's survivors if accepted.
  task automatic model_edge();
    wr_t e;
    bit  keep;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      m_rf_wr   = 1'b1;
      m_rf_dest = e.dest;
      m_rf_data = e.data;
    end else begin
      m_rf_wr = 1'b0;
    end
    if (!m_stall && !flush) begin
      for (int p = 0; p < 3; p++) begin
        keep = wr[p];
        for (int r = p + 1; r < 3; r++)
          if (wr[r] && dest[r] == dest[p]) keep = 0;
        if (keep) begin
          e.dest = dest[p];
          e.data = data[p];
          q.push_back(e);
        end
      end
    end
    m_stall = (DEPTH - q.size()) < 3;
  endtask

  function automatic logic [2**ADDR_W-1:0] model_pending();
    logic [2**ADDR_W-1:0] m;
    m = '0;
    foreach (q[i]) m[q[i].dest] = 1'b1;
    if (m_rf_wr) m[m_rf_dest] = 1'b1;
    return m;
  endfunction

  task automatic checkOutput();
    if (stall === 1'b1) saw_stall = 1;
    check("stall",   64'(stall),   64'(m_stall));
    check("rf_wr",   64'(rf_wr),   64'(m_rf_wr));
    check("rf_dest", 64'(rf_dest), 64'(m_rf_dest));
    check("rf_data", 64'(rf_data), 64'(m_rf_data));
    check("count",   64'(count),   64'(q.size()));
    check("pending", 64'(pending), 64'(model_pending()));
  endtask

  // Advance one edge, update the model, then sample 1ns later.
  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [2:0] w,
                               input logic [ADDR_W-1:0] d1, d2, d3,
                               input logic [DATA_W-1:0] x1, x2, x3,
                               input logic f);
    wr = w; flush = f;
    dest[0] = d1; dest[1] = d2; dest[2] = d3;
    data[0] = x1; data[1] = x2; data[2] = x3;
  endtask

  task automatic idle(input int n);
    applyStimulus(3'b000, '0, '0, '0, '0, '0, '0, 1'b0);
    repeat (n) cycle();
  endtask

  // Present a bundle and hold it until the arbiter takes it (bounded).
  task automatic send(input logic [2:0] w,
                      input logic [ADDR_W-1:0] d1, d2, d3,
                      input logic [DATA_W-1:0] x1, x2, x3);
    bit acc;
    int n = 0;
    applyStimulus(w, d1, d2, d3, x1, x2, x3, 1'b0);
    forever begin
      acc = !m_stall;
      cycle();
      n++;
      if (acc) break;
      if (n >= 20) begin
        check("accept_timeout", 64'(n), 64'(0));
        break;
      end
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] t2_dest [4];
    logic [DATA_W-1:0] t2_data [4];
    bit hold;

    reset_n = 1'b0;
    applyStimulus(3'b000, '0, '0, '0, '0, '0, '0, 1'b0);
    model_reset();
    #2;
    phase = "reset";
    checkOutput();
    #10 reset_n = 1'b1;
    idle(2);

    // Three writes into an empty queue drain on consecutive cycles.
    phase = "t2";
    send(3'b111, 4'd1, 4'd2, 4'd3, 64'hA, 64'hB, 64'hC);
    check("count_after_accept", 64'(count), 64'd3);
    check("rf_wr_after_accept", 64'(rf_wr), 64'd0);
    applyStimulus(3'b000, '0, '0, '0, '0, '0, '0, 1'b0);
    t2_dest[0] = 4'd1; t2_dest[1] = 4'd2; t2_dest[2] = 4'd3;
    t2_data[0] = 64'hA; t2_data[1] = 64'hB; t2_data[2] = 64'hC;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("drain_wr",    64'(rf_wr),   64'd1);
      check("drain_dest",  64'(rf_dest), 64'(t2_dest[i]));
      check("drain_data",  64'(rf_data), t2_data[i]);
      check("drain_count", 64'(count),   64'(2 - i));
    end
    cycle();
    check("drain_done", 64'(rf_wr), 64'd0);

    // Pipe1 and pipe3 share dest 5: only pipe3's write survives.
    phase = "t3";
    send(3'b111, 4'd5, 4'd6, 4'd5, 64'h11, 64'h22, 64'h33);
    check("count_collide", 64'(count), 64'd2);
    applyStimulus(3'b000, '0, '0, '0, '0, '0, '0, 1'b0);
    cycle();
    check("first_dest", 64'(rf_dest), 64'd6);
    check("first_data", 64'(rf_data), 64'h22);
    cycle();
    check("second_dest", 64'(rf_dest), 64'd5);
    check("second_data", 64'(rf_data), 64'h33);
    idle(2);
    check("pending_clear", 64'(pending), 64'd0);

    // Full bundles back to back drive the queue into stall.
    phase = "t4";
    for (int b = 0; b < 8; b++)
      send(3'b111, ADDR_W'(3*b % 16), ADDR_W'((3*b+1) % 16), ADDR_W'((3*b+2) % 16),
           64'(100*b + 1), 64'(100*b + 2), 64'(100*b + 3));
    check("stall_seen", 64'(saw_stall), 64'd1);
    idle(DEPTH + 2);

    // Flushed bundle is dropped; earlier queued bundles drain untouched.
    phase = "t5";
    send(3'b011, 4'd7, 4'd8, 4'd0, 64'h71, 64'h81, 64'h0);
    send(3'b001, 4'd9, 4'd0, 4'd0, 64'h91, 64'h0, 64'h0);
    applyStimulus(3'b111, 4'd10, 4'd11, 4'd12, 64'hAA, 64'hBB, 64'hCC, 1'b1);
    cycle();
    idle(6);
    check("flush_empty", 64'(count), 64'd0);

    // Lone pipe-2 write.
    phase = "t6";
    send(3'b010, 4'd0, 4'hF, 4'd0, 64'h0, 64'hDEAD, 64'h0);
    check("t6_count1", 64'(count), 64'd1);
    applyStimulus(3'b000, '0, '0, '0, '0, '0, '0, 1'b0);
    cycle();
    check("t6_wr",    64'(rf_wr),   64'd1);
    check("t6_dest",  64'(rf_dest), 64'hF);
    check("t6_data",  64'(rf_data), 64'hDEAD);
    check("t6_count0", 64'(count),  64'd0);
    cycle();
    check("t6_wr_low", 64'(rf_wr), 64'd0);

    // Asynchronous reset in the middle of a drain.
    phase = "t1";
    send(3'b111, 4'd1, 4'd2, 4'd3, 64'h1, 64'h2, 64'h3);
    send(3'b111, 4'd4, 4'd5, 4'd6, 64'h4, 64'h5, 64'h6);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    checkOutput();
    @(posedge clock);
    model_edge();
    #1;
    checkOutput();
    #2 reset_n = 1'b1;
    idle(4);

    // Randomized traffic; held bundles persist while stalled.
    phase = "rand";
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (!hold)
        applyStimulus(3'($urandom), ADDR_W'($urandom_range(0, 3)),
                      ADDR_W'($urandom_range(0, 3)), ADDR_W'($urandom_range(0, 3)),
                      {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                      ($urandom_range(0, 7) == 0));
      hold = m_stall;
      cycle();
    end
    idle(DEPTH + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
